dispatch_sequencer: RTL
=======================

// Module: dispatch_sequencer
// PURPOSE
//  Top-level transfer sequencer for one LeNet5 layer pass. Drives FSM_data and write_halt of
//  data_dispatcher and issues burst commands to the AXI master: weight load, ifmap load, zero
//  padding, wait for PE array completion, ofmap offload. Splits each segment into bursts of
//  at most MAX_BURST 64-bit beats.
// PARAMETERS
//  ADDR_W     32   byte-address width of cmd_addr / *_base
//  LEN_W      14   beat-count width of *_beats and cmd_len
//  MAX_BURST  256  max beats per command (power of 2, <= 2**LEN_W-1)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       synchronous reset, active-high
//  start       in   1       1-cycle pulse; latches config; ignored while busy
//  wght_base   in   ADDR_W  weight segment byte address (8-byte aligned)
//  wght_beats  in   LEN_W   weight beats, 0 = skip segment
//  ifmap_base  in   ADDR_W  ifmap segment byte address
//  ifmap_beats in   LEN_W   ifmap beats, 0 = skip
//  pad_beats   in   LEN_W   zero-fill beats after ifmap, 0 = skip
//  ofmap_base  in   ADDR_W  ofmap segment byte address
//  ofmap_beats in   LEN_W   ofmap beats, 0 = skip
//  cmd_valid   out  1       burst command valid
//  cmd_ready   in   1       master accepts command when cmd_valid&cmd_ready
//  cmd_rnw     out  1       1 = read (load), 0 = write (offload)
//  cmd_addr    out  ADDR_W  burst start byte address
//  cmd_len     out  LEN_W   burst beats, 1..MAX_BURST
//  rd_valid    in   1       one read beat delivered on ctrl2pe
//  wr_ready    in   1       master consumes one write beat this cycle
//  pe_done     in   1       PE array finished computing (level or pulse)
//  FSM_data    out  4       state code to data_dispatcher
//  write_halt  out  1       hold ofmap beat in dispatcher
//  busy        out  1       high from accepted start until done
//  done        out  1       1-cycle pulse when pass completes
// BEHAVIOUR
//  - States (FSM_data code): IDLE 0, WREQ 1, WBURST 2, WCMPLT 3, IREQ 4, IBURST 5, ICMPLT 6,
//    ZFILL 7, OREQ 8, OBURST 9, OCMPLT 10, WAIT_PE 11. FSM_data = state register, no decode.
//  - Reset: state IDLE, cmd_valid 0, write_halt 0, busy 0, done 0, cmd_addr/cmd_len 0, counters 0.
//    rst mid-transfer aborts immediately; no command completion is awaited.
//  - IDLE + start: latch all config, busy=1, go to first non-empty segment in order
//    W, I, Z, WAIT_PE, O (WAIT_PE is never skipped). Empty segment: no command is issued.
//  - xREQ: cmd_valid=1, cmd_addr=seg addr, cmd_len=min(remaining,MAX_BURST), cmd_rnw=1 for W/I,
//    0 for O. Outputs stable until cmd_ready; on handshake go to xBURST, beat cnt=0.
//  - WBURST/IBURST: cnt++ on rd_valid; on the beat where cnt==cmd_len-1, go to xCMPLT.
//  - OBURST: cnt++ on wr_ready; write_halt = (state==OBURST) & ~wr_ready (combinational).
//    write_halt=0 in all other states.
//  - xCMPLT (1 cycle): remaining -= cmd_len; addr += cmd_len*8. If remaining != 0, go to xREQ.
//    Else next segment: W->I->Z->WAIT_PE; I->Z->WAIT_PE; O->IDLE with done=1, busy=0.
//  - ZFILL: exactly pad_beats cycles, then WAIT_PE.
//  - WAIT_PE: go to OREQ (or IDLE+done if ofmap_beats==0) the cycle after pe_done is seen high.
//  - rd_valid/wr_ready outside burst states: ignored, no count change.
//  - start during busy: dropped, config not relatched.
//  - Address arithmetic: mod 2**ADDR_W (wraps); no 4KB-boundary split (software aligns).
// TESTING
//  1. wght_beats=10, ifmap=0, pad=0, ofmap=0, pe_done pulse -> one read cmd len 10;
//     FSM 1,2..,3,11,0; done pulse.
//  2. wght_beats=600, base 0x1000 -> cmds (0x1000,256), (0x1800,256), (0x2000,88);
//     three WCMPLT passes.
//  3. ifmap=4, pad=3 -> IBURST counts 4 rd_valid incl. gaps; ZFILL exactly 3 cycles; then WAIT_PE.
//  4. ofmap=5, wr_ready toggles 1,0,0,1,1,0,1,1 -> write_halt high exactly on the 3 low cycles;
//     OCMPLT after 5th ready.
//  5. cmd_ready held low 20 cycles -> cmd_valid/addr/len stable; start pulse mid-pass ignored.
//  6. rst asserted during OBURST -> next cycle FSM_data=0, cmd_valid=0, busy=0;
//     fresh start runs normally.

Source files
------------

// File: rtl/dispatch_sequencer.sv
// Layer-pass transfer sequencer: weight/ifmap loads, zero padding, PE wait and ofmap
// offload, with each segment split into bursts of at most MAX_BURST beats.
module dispatch_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 14,
  parameter int MAX_BURST = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] wght_base,
  input  logic [LEN_W-1:0]  wght_beats,
  input  logic [ADDR_W-1:0] ifmap_base,
  input  logic [LEN_W-1:0]  ifmap_beats,
  input  logic [LEN_W-1:0]  pad_beats,
  input  logic [ADDR_W-1:0] ofmap_base,
  input  logic [LEN_W-1:0]  ofmap_beats,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_rnw,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              rd_valid,
  input  logic              wr_ready,
  input  logic              pe_done,
  output logic [3:0]        FSM_data,
  output logic              write_halt,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,  WREQ   = 4'd1,  WBURST = 4'd2,  WCMPLT  = 4'd3,
    IREQ    = 4'd4,  IBURST = 4'd5,  ICMPLT = 4'd6,  ZFILL   = 4'd7,
    OREQ    = 4'd8,  OBURST = 4'd9,  OCMPLT = 4'd10, WAIT_PE = 4'd11
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] seg_addr, ifmap_base_q, ofmap_base_q, addr_next;
  logic [LEN_W-1:0]  remaining, cnt, rem_left;
  logic [LEN_W-1:0]  ifmap_beats_q, pad_beats_q, ofmap_beats_q;
  logic [ADDR_W-1:0] eff_ifmap_base, i_addr;
  logic [LEN_W-1:0]  eff_ifmap_beats, eff_pad, i_rem, z_rem;
  state_t            i_state, z_state;

  // cmd_len is derived from remaining, which only changes in xCMPLT, so it holds
  // steady through the whole request/burst of a command.
  assign cmd_len    = (remaining > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : remaining;
  assign cmd_addr   = seg_addr;
  assign cmd_valid  = (state == WREQ) || (state == IREQ) || (state == OREQ);
  assign cmd_rnw    = !((state == OREQ) || (state == OBURST) || (state == OCMPLT));
  assign write_halt = (state == OBURST) && !wr_ready;
  assign FSM_data   = state;
  assign rem_left   = remaining - cmd_len;
  assign addr_next  = seg_addr + (ADDR_W'(cmd_len) << 3);

  // Segment entry after W (or directly from IDLE): in IDLE the live inputs are used
  // because the config is being latched on that same edge.
  always_comb begin
    eff_ifmap_base  = (state == IDLE) ? ifmap_base  : ifmap_base_q;
    eff_ifmap_beats = (state == IDLE) ? ifmap_beats : ifmap_beats_q;
    eff_pad         = (state == IDLE) ? pad_beats   : pad_beats_q;
    if (eff_pad != '0) begin
      z_state = ZFILL;
      z_rem   = eff_pad;
    end else begin
      z_state = WAIT_PE;
      z_rem   = '0;
    end
    i_addr = eff_ifmap_base;
    if (eff_ifmap_beats != '0) begin
      i_state = IREQ;
      i_rem   = eff_ifmap_beats;
    end else begin
      i_state = z_state;
      i_rem   = z_rem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      seg_addr      <= '0;
      remaining     <= '0;
      cnt           <= '0;
      ifmap_base_q  <= '0;
      ofmap_base_q  <= '0;
      ifmap_beats_q <= '0;
      pad_beats_q   <= '0;
      ofmap_beats_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy          <= 1'b1;
          ifmap_base_q  <= ifmap_base;
          ifmap_beats_q <= ifmap_beats;
          pad_beats_q   <= pad_beats;
          ofmap_base_q  <= ofmap_base;
          ofmap_beats_q <= ofmap_beats;
          if (wght_beats != '0) begin
            state     <= WREQ;
            seg_addr  <= wght_base;
            remaining <= wght_beats;
          end else begin
            state     <= i_state;
            seg_addr  <= i_addr;
            remaining <= i_rem;
          end
        end
        WREQ: if (cmd_ready) begin state <= WBURST; cnt <= '0; end
        IREQ: if (cmd_ready) begin state <= IBURST; cnt <= '0; end
        OREQ: if (cmd_ready) begin state <= OBURST; cnt <= '0; end
        WBURST, IBURST: if (rd_valid) begin
          cnt <= cnt + LEN_W'(1);
          if (cnt == cmd_len - LEN_W'(1)) state <= (state == WBURST) ? WCMPLT : ICMPLT;
        end
        OBURST: if (wr_ready) begin
          cnt <= cnt + LEN_W'(1);
          if (cnt == cmd_len - LEN_W'(1)) state <= OCMPLT;
        end
        WCMPLT: begin
          remaining <= rem_left;
          seg_addr  <= addr_next;
          if (rem_left != '0) state <= WREQ;
          else begin
            state     <= i_state;
            seg_addr  <= i_addr;
            remaining <= i_rem;
          end
        end
        ICMPLT: begin
          seg_addr  <= addr_next;
          remaining <= rem_left;
          if (rem_left != '0) state <= IREQ;
          else begin
            state     <= z_state;
            remaining <= z_rem;
          end
        end
        OCMPLT: begin
          remaining <= rem_left;
          seg_addr  <= addr_next;
          if (rem_left != '0) state <= OREQ;
          else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ZFILL: begin
          if (remaining <= LEN_W'(1)) begin
            state     <= WAIT_PE;
            remaining <= '0;
          end else remaining <= remaining - LEN_W'(1);
        end
        WAIT_PE: if (pe_done) begin
          if (ofmap_beats_q != '0) begin
            state     <= OREQ;
            seg_addr  <= ofmap_base_q;
            remaining <= ofmap_beats_q;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
